tt_sweep_capture: RTL and testbench

Exhaustive truth-table sweeper for the synthesized single-output benchmark netlists (8 inputs, 1 output, `y0 = f(x0..x7)`). It drives every input vector into a device under test (DUT) and reads back the DUT's output. From those samples it builds the full truth table, a ones count and a signature register (MISR) value. It then compares the signature against an expected value, so an original netlist and its optimized netlist can be checked for equivalence in hardware. The DUT itself stays a pure combinational or pipelined function.

---
 rtl/tt_sweep_pkg.sv | 29 ++
 rtl/tt_sweep_delay.sv | 44 ++++
 rtl/tt_sweep_capture.sv | 128 ++++++++++++
 tb/tb_tt_sweep_capture.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper and its reference model.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int unsigned SIG_W_MAX    = 32;
  localparam logic [15:0] SIG_POLY_DEF = 16'h1021;
  localparam logic [15:0] SIG_SEED_DEF = 16'h0000;

  // One Galois MISR step on a w-bit register (w <= SIG_W_MAX), upper bits forced to zero.
  function automatic logic [SIG_W_MAX-1:0] misr_step(
    input logic [SIG_W_MAX-1:0] cur,
    input logic                 din,
    input logic [SIG_W_MAX-1:0] poly,
    input int unsigned          w
  );
    logic [SIG_W_MAX-1:0] mask;
    logic [SIG_W_MAX-1:0] nxt;
    mask = (w >= SIG_W_MAX) ? '1 : ((SIG_W_MAX'(1) << w) - SIG_W_MAX'(1));
    nxt  = (cur << 1) ^ (cur[w-1] ? poly : '0) ^ {{(SIG_W_MAX-1){1'b0}}, din};
    return nxt & mask;
  endfunction

endpackage

// File: rtl/tt_sweep_delay.sv
// Aligns {valid, index} of each driven vector with the DUT output LAT cycles later.
module tt_sweep_delay #(
  parameter int unsigned LAT = 0,
  parameter int unsigned W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         src_valid,
  input  logic [W-1:0] src_idx,
  output logic         tap_valid,
  output logic [W-1:0] tap_idx
);

  generate
    if (LAT == 0) begin : g_wire
      // Clock and reset are idle in the zero-latency build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign tap_valid      = src_valid;
      assign tap_idx        = src_idx;
    end else begin : g_pipe
      logic [LAT-1:0] vld;
      logic [W-1:0]   idx [LAT];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld <= '0;
          for (int i = 0; i < int'(LAT); i++) idx[i] <= '0;
        end else begin
          vld[0] <= src_valid;
          idx[0] <= src_idx;
          for (int i = 1; i < int'(LAT); i++) begin
            vld[i] <= vld[i-1];
            idx[i] <= idx[i-1];
          end
        end
      end

      assign tap_valid = vld[LAT-1];
      assign tap_idx   = idx[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/tt_sweep_capture.sv
// Exhaustive input sweep of a single-output DUT: captures truth table, ones count and MISR signature.
module tt_sweep_capture
  import tt_sweep_pkg::*;
#(
  parameter int unsigned       N_IN     = 8,
  parameter int unsigned       DUT_LAT  = 0,
  parameter int unsigned       SIG_W    = 16,
  parameter logic [SIG_W-1:0]  SIG_POLY = SIG_W'(SIG_POLY_DEF),
  parameter logic [SIG_W-1:0]  SIG_SEED = SIG_W'(SIG_SEED_DEF)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [N_IN-1:0]          x_out,
  input  logic                     y_in,
  input  logic [SIG_W-1:0]         exp_sig,
  output logic                     busy,
  output logic                     done,
  output logic [(1<<N_IN)-1:0]     tt_out,
  output logic [N_IN:0]            ones_cnt,
  output logic [SIG_W-1:0]         sig,
  output logic                     match
);

  localparam int unsigned TT_W      = 1 << N_IN;
  localparam int unsigned CNT_W     = N_IN + 1;
  localparam int unsigned DRN_W     = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
  localparam int unsigned DRN_LAST  = (DUT_LAT > 0) ? DUT_LAT - 1 : 0;

  state_e             state;
  state_e             state_d;
  logic [DRN_W-1:0]   drain_cnt;
  logic [SIG_W-1:0]   exp_q;
  logic               accept_c;
  logic               last_vec_c;
  logic               drain_end_c;
  logic               cap_valid;
  logic [N_IN-1:0]    cap_idx;
  logic [SIG_W-1:0]   sig_d;
  logic [CNT_W-1:0]   ones_d;

  tt_sweep_delay #(
    .LAT (DUT_LAT),
    .W   (N_IN)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .src_valid (state == S_RUN),
    .src_idx   (x_out),
    .tap_valid (cap_valid),
    .tap_idx   (cap_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d     = state;
    accept_c    = 1'b0;
    last_vec_c  = (x_out == '1);
    drain_end_c = (drain_cnt == DRN_W'(DRN_LAST));
    case (state)
      S_IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (last_vec_c) state_d = (DUT_LAT > 0) ? S_DRAIN : S_DONE;
      end
      S_DRAIN: begin
        if (drain_end_c) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next signature and count for the sample arriving this cycle.
  always_comb begin
    sig_d  = sig;
    ones_d = ones_cnt;
    if (cap_valid) begin
      sig_d  = SIG_W'(misr_step(SIG_W_MAX'(sig), y_in, SIG_W_MAX'(SIG_POLY), SIG_W));
      ones_d = ones_cnt + CNT_W'(y_in);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_out     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tt_out    <= '0;
      ones_cnt  <= '0;
      sig       <= '0;
      match     <= 1'b0;
      exp_q     <= '0;
      drain_cnt <= '0;
    end else begin
      busy <= (state_d != S_IDLE);
      done <= (state_d == S_DONE);
      if (accept_c) begin
        x_out     <= '0;
        tt_out    <= TT_W'(0);
        ones_cnt  <= '0;
        sig       <= SIG_SEED;
        match     <= 1'b0;
        exp_q     <= exp_sig;
        drain_cnt <= '0;
      end else begin
        // The index holds at all ones after the last vector rather than wrapping.
        if (state == S_RUN && !last_vec_c) x_out <= x_out + N_IN'(1);
        if (state == S_DRAIN) drain_cnt <= drain_cnt + DRN_W'(1);
        if (cap_valid) begin
          tt_out[cap_idx] <= y_in;
          ones_cnt        <= ones_d;
          sig             <= sig_d;
        end
        if (state_d == S_DONE) match <= (sig_d == exp_q);
      end
    end
  end

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: zero- and two-cycle-latency instances checked against a truth-table model.
module tb_tt_sweep_capture;
  import tt_sweep_pkg::*;

  localparam int unsigned CW   = 300;
  localparam logic [7:0]  MINT = 8'd77;
  typedef logic [CW-1:0] cv_t;

  typedef struct {
    int inst;
    int mode;
    int ref_kind;
    logic exp_match;
    int chk_mint;
  } vec_t;

  typedef struct {
    logic [255:0] tt;
    logic [8:0]   ones;
    logic [15:0]  sig;
    logic         match;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start0, y0, busy0, done0, match0;
  logic [15:0]  exp0, sig0;
  logic [7:0]   x0;
  logic [255:0] tt0;
  logic [8:0]   ones0;
  logic         start2, y2, busy2, done2, match2;
  logic [15:0]  exp2, sig2;
  logic [7:0]   x2;
  logic [255:0] tt2;
  logic [8:0]   ones2;

  tt_sweep_capture #(.N_IN(8), .DUT_LAT(0), .SIG_W(16)) u_lat0 (
    .clk(clk), .rst(rst), .start(start0), .x_out(x0), .y_in(y0), .exp_sig(exp0),
    .busy(busy0), .done(done0), .tt_out(tt0), .ones_cnt(ones0), .sig(sig0), .match(match0)
  );

  tt_sweep_capture #(.N_IN(8), .DUT_LAT(2), .SIG_W(16)) u_lat2 (
    .clk(clk), .rst(rst), .start(start2), .x_out(x2), .y_in(y2), .exp_sig(exp2),
    .busy(busy2), .done(done2), .tt_out(tt2), .ones_cnt(ones2), .sig(sig2), .match(match2)
  );

  int          errors = 0;
  int          checks = 0;
  int          mode_r [2];
  logic [7:0]  last_x [2];
  int          sel;
  exp_t        sb [$];
  vec_t        vecs [7];

  // Two-stage registered copy of x_out[7] for each instance.
  logic [1:0] p0, p2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0 <= 2'b00;
      p2 <= 2'b00;
    end else begin
      p0 <= {p0[0], x0[7]};
      p2 <= {p2[0], x2[7]};
    end
  end

  function automatic logic gold(input logic [7:0] x);
    return (x[0] & x[1]) ^ (x[2] | x[5]) ^ (x[7] & ~x[3]) ^ (x[4] & x[6]);
  endfunction

  function automatic logic ymux(input int m, input logic [7:0] x, input logic pb);
    case (m)
      0:       return x[0];
      1:       return 1'b1;
      2:       return pb;
      3:       return gold(x);
      4:       return gold(x) ^ (x == MINT);
      default: return 1'b0;
    endcase
  endfunction

  always_comb y0 = ymux(mode_r[0], x0, p0[1]);
  always_comb y2 = ymux(mode_r[1], x2, p2[1]);

  logic         s_busy, s_done, s_match;
  logic [7:0]   s_x;
  logic [255:0] s_tt;
  logic [8:0]   s_ones;
  logic [15:0]  s_sig;
  always_comb begin
    if (sel == 0) begin
      s_busy = busy0; s_done = done0; s_match = match0; s_x = x0;
      s_tt = tt0; s_ones = ones0; s_sig = sig0;
    end else begin
      s_busy = busy2; s_done = done2; s_match = match2; s_x = x2;
      s_tt = tt2; s_ones = ones2; s_sig = sig2;
    end
  end

  // x_out value in the cycle at offset o from the accepting edge.
  function automatic logic [7:0] xv(input int o, input logic [7:0] last);
    if (o <= 0) return last;
    if (o - 1 > 255) return 8'hFF;
    return 8'(o - 1);
  endfunction

  function automatic logic [255:0] model_tt(input int m, input int lat, input logic [7:0] last);
    logic [255:0] t;
    logic [7:0]   xs, xd;
    for (int i = 0; i < 256; i++) begin
      xs   = xv(1 + i + lat, last);
      xd   = xv(i + lat - 1, last);
      t[i] = ymux(m, xs, xd[7]);
    end
    return t;
  endfunction

  function automatic logic [15:0] model_sig(input logic [255:0] t);
    logic [15:0] s;
    s = SIG_SEED_DEF;
    for (int i = 0; i < 256; i++)
      s = 16'(misr_step(32'(s), t[i], 32'(SIG_POLY_DEF), 16));
    return s;
  endfunction

  function automatic logic [8:0] popc(input logic [255:0] t);
    logic [8:0] c;
    c = 9'd0;
    for (int i = 0; i < 256; i++) c = c + 9'(t[i]);
    return c;
  endfunction

  task automatic check(input string name, input cv_t act, input cv_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int inst, input int mode, input int ref_kind,
                          input logic em, output logic [15:0] es);
    exp_t         e;
    logic [255:0] rtt;
    int           lat;
    lat     = (inst == 0) ? 0 : 2;
    e.tt    = model_tt(mode, lat, last_x[inst]);
    e.ones  = popc(e.tt);
    e.sig   = model_sig(e.tt);
    e.match = em;
    e.lat   = 257 + lat;
    case (ref_kind)
      1:       rtt = model_tt(3, 0, 8'h00);
      2:       rtt = model_tt(2, 2, 8'h00);
      default: rtt = e.tt;
    endcase
    es = model_sig(rtt);
    sb.push_back(e);
  endtask

  task automatic drive_start(input int inst, input logic [15:0] es);
    @(negedge clk);
    sel = inst;
    if (inst == 0) begin start0 = 1'b1; exp0 = es; end
    else           begin start2 = 1'b1; exp2 = es; end
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;
  endtask

  // Follows one sweep from offset 1 to done; optionally re-raises start mid-sweep and leaves it high.
  task automatic track_sweep(input int inst, input int hold_at);
    int         off;
    int         busy_n;
    int         bad_x;
    int         done_off;
    logic [7:0] ex;
    exp_t       e;
    off = 1; busy_n = 0; bad_x = 0; done_off = 0;
    while (off <= 700) begin
      if (hold_at != 0 && off == hold_at) begin
        if (inst == 0) start0 = 1'b1; else start2 = 1'b1;
      end
      ex = xv(off, 8'h00);
      if (s_x !== ex) bad_x++;
      if (s_busy) busy_n++;
      if (s_done) begin
        done_off = off;
        break;
      end
      @(negedge clk);
      off++;
    end
    if (sb.size() == 0) begin
      errors++; checks++;
      $display("FAIL scoreboard: got empty queue expected entry");
      return;
    end
    e = sb.pop_front();
    check("done_cycle",  cv_t'(done_off), cv_t'(e.lat));
    check("busy_cycles", cv_t'(busy_n),   cv_t'(e.lat));
    check("x_out_seq",   cv_t'(bad_x),    cv_t'(0));
    check("tt_out",      cv_t'(s_tt),     cv_t'(e.tt));
    check("ones_cnt",    cv_t'(s_ones),   cv_t'(e.ones));
    check("sig",         cv_t'(s_sig),    cv_t'(e.sig));
    check("match",       cv_t'(s_match),  cv_t'(e.match));
    @(negedge clk);
    check("idle_after_done", cv_t'({s_busy, s_done, s_x}), cv_t'({1'b0, 1'b0, 8'hFF}));
    last_x[inst] = 8'hFF;
  endtask

  initial begin
    logic [15:0]  es;
    logic [255:0] onehot;
    int           bad;

    vecs[0] = '{0, 0, 0, 1'b1, 0};
    vecs[1] = '{0, 1, 0, 1'b1, 0};
    vecs[2] = '{1, 2, 0, 1'b1, 0};
    vecs[3] = '{0, 2, 2, 1'b0, 0};
    vecs[4] = '{0, 3, 0, 1'b1, 0};
    vecs[5] = '{0, 4, 1, 1'b0, 1};
    vecs[6] = '{1, 1, 0, 1'b1, 0};

    rst = 1'b1; start0 = 1'b0; start2 = 1'b0; exp0 = 16'h0; exp2 = 16'h0;
    sel = 0; mode_r[0] = 0; mode_r[1] = 0; last_x[0] = 8'h00; last_x[1] = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_lat0", cv_t'({x0, busy0, done0, tt0, ones0, sig0, match0}), cv_t'(0));
    check("reset_lat2", cv_t'({x2, busy2, done2, tt2, ones2, sig2, match2}), cv_t'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int r = 0; r < 7; r++) begin
      mode_r[vecs[r].inst] = vecs[r].mode;
      repeat (3) @(negedge clk);
      push_exp(vecs[r].inst, vecs[r].mode, vecs[r].ref_kind, vecs[r].exp_match, es);
      drive_start(vecs[r].inst, es);
      track_sweep(vecs[r].inst, 0);
      if (vecs[r].chk_mint != 0) begin
        onehot = 256'd0;
        onehot[MINT] = 1'b1;
        check("mint_diff", cv_t'(s_tt ^ model_tt(3, 0, 8'h00)), cv_t'(onehot));
      end
    end

    // start re-raised mid-sweep and held through DONE.
    mode_r[0] = 0;
    repeat (3) @(negedge clk);
    push_exp(0, 0, 0, 1'b1, es);
    drive_start(0, es);
    track_sweep(0, 50);
    push_exp(0, 0, 0, 1'b1, es);
    exp0 = es;
    @(negedge clk);
    check("restart_after_busy", cv_t'({busy0, x0}), cv_t'({1'b1, 8'h00}));
    start0 = 1'b0;
    track_sweep(0, 0);

    // Reset in the cycle that drives vector 100.
    mode_r[0] = 3;
    repeat (3) @(negedge clk);
    drive_start(0, 16'h0);
    repeat (100) @(negedge clk);
    check("x_at_reset", cv_t'(x0), cv_t'(100));
    rst = 1'b1;
    #1;
    check("async_reset_lat0", cv_t'({x0, busy0, done0, tt0, ones0, sig0, match0}), cv_t'(0));
    check("async_reset_lat2", cv_t'({x2, busy2, done2, tt2, ones2, sig2, match2}), cv_t'(0));
    @(negedge clk);
    rst = 1'b0;
    last_x[0] = 8'h00;
    last_x[1] = 8'h00;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done0 || busy0) bad++;
    end
    check("no_done_after_reset", cv_t'(bad), cv_t'(0));
    push_exp(0, 3, 0, 1'b1, es);
    drive_start(0, es);
    track_sweep(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
